alu_md_controller: RTL and testbench
====================================

Name: alu_md_controller

Overview:
- Next-generation ALU controller for the RV32/RV64 pipeline EX stage.
- Keeps the base 4-bit ALU operation decode.
- Adds RV-M decode (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with an iterative multiply/divide engine.
- Issues a pipeline stall while an M-op executes and returns the result through an EX-stage result mux select.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- ENABLE_M, 1, when 0 the M decode is disabled: is_m is forced 0, stall_o and md_sel are never asserted, and md_done is never asserted.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  instruction in EX is valid
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/JALR/LUI
- Funct7  in  7  instr[31:25]
- Funct3  in  3  instr[14:12]
- RTypeID  in  1  1 = R-type, 0 = I-type
- flush_i  in  1  EX flush (branch mispredict/trap)
- src_a  in  XLEN  rs1 operand
- src_b  in  XLEN  rs2 operand
- Operation  out  4  base ALU operation
- md_sel  out  1  EX result mux selects md_result
- stall_o  out  1  freeze IF/ID/EX
- md_done  out  1  md_result valid, one-cycle pulse
- md_result  out  XLEN  M-op result

Behaviour:
- Clock and reset: single clock. reset is asynchronous and active-high.
- Reset state: state=IDLE, cnt=0, md_result=0, md_done=0, internal accumulators=0.
- Base decode (combinational):
  - Encoding: AND 0000, OR 0001, ADD 0010, JAL 0011, SLT 0100, XOR 0101, SUB 0110, JALR 0111, BEQ 1000, BNE 1001, BLT 1010, BGE 1011, SLL 1101, SRL 1110, SRA 1111.
  - ALUOp 00 -> ADD. ALUOp 11 -> JALR.
  - ALUOp 01: funct3 000/001/100/101 -> BEQ/BNE/BLT/BGE.
  - ALUOp 10: funct3 000 -> ADD, or SUB if Funct7=0100000 and RTypeID=1.
  - ALUOp 10: 001 SLL, 010 SLT, 100 XOR, 101 SRL (Funct7=0000000) / SRA (Funct7=0100000), 110 OR, 111 AND.
- M-op detection: is_m = ENABLE_M & ALUOp==10 & RTypeID & Funct7==0000001.
  - While is_m: Operation=0000 and md_sel=1.
- FSM states: IDLE, BUSY, DONE.
- Issue: IDLE & valid_i & is_m & !flush_i.
  - Latches src_a, src_b, Funct3 and operand signs.
  - Goes to BUSY with cnt=XLEN-1, or to DONE directly for fast-path cases.
- Fast path (resolved in the issue cycle, result registered into DONE):
  - DIV/DIVU with src_b=0: quotient all ones.
  - REM/REMU with src_b=0: result = src_a.
  - DIV with src_a=MIN_INT and src_b=-1: result = MIN_INT. REM with the same operands: result = 0.
- BUSY:
  - One radix-2 step per cycle: shift-add multiply or restoring divide, on magnitudes.
  - cnt decrements each cycle. At cnt==0: apply sign correction, register md_result, go to DONE.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU, DIVU, REMU: unsigned.
  - MUL returns the low XLEN bits. MULH* return the high XLEN bits of the 2*XLEN product.
  - Quotient sign = sa^sb. Remainder sign = sign of dividend.
- DONE: md_done=1 for one cycle, stall_o=0, then IDLE unconditionally.
  - No issue occurs in DONE; the same instruction is still in EX and advances this cycle.
- stall_o = (issue | state==BUSY) & !flush_i.
  - Normal op: stall_o high for XLEN+1 cycles.
  - Fast path: stall_o high for 1 cycle.
- Back-to-back M-ops: the next issue occurs in the IDLE cycle following DONE.
- md_result holds its value until the next DONE load.
- flush_i in any state: stall_o=0 that cycle, state=IDLE next edge, no md_done, md_result unchanged.
- Inputs during BUSY are ignored; the operands are latched copies.
- reset asserted mid-operation: immediate return to the reset state, no md_done.

Test Plan:
- Base decode: ALUOp=10, Funct3=000, Funct7=0100000, RTypeID=1 -> Operation=0110. The same with RTypeID=0 -> 0010. Funct3=101, Funct7=0100000 -> 1111. ALUOp=01, Funct3=101 -> 1011.
- MUL, XLEN=32: src_a=7, src_b=0xFFFFFFFD -> stall_o high 33 cycles, then md_done pulse, md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Divide corners:
  - DIV 0x80000000 / 0xFFFFFFFF -> 1 stall cycle, md_result=0x80000000. REM with the same operands -> 0.
  - DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5.
- Signed remainder: REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF. DIV with the same operands -> 0xFFFFFFFD (-3).
- flush_i asserted on BUSY cycle 10 -> stall_o low that cycle, IDLE next, no md_done, md_result holds its prior value. A subsequent MUL 3*4 -> 12 after 33 stall cycles.
- Async reset mid-BUSY: reset pulsed between clock edges -> stall_o, md_done and md_result go to 0 without a clock edge. Two back-to-back DIVs (100/7 then 100/-7) -> 14, then 0xFFFFFFF2, each with 33 stall cycles and an IDLE cycle between them.

Source files
------------

// File: rtl/alu_md_controller.sv
// EX-stage ALU controller: base ALU operation decode plus an iterative
// RV-M multiply/divide engine that stalls the pipeline while it runs.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   valid_i            instruction in EX is valid
//   ALUOp              00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/JALR/LUI
//   Funct7, Funct3     instruction function fields
//   RTypeID            1 = R-type, 0 = I-type
//   flush_i            EX flush (mispredict / trap)
//   src_a, src_b       rs1 / rs2 operands
//   Operation          base ALU operation code
//   md_sel             EX result mux selects md_result
//   stall_o            freeze IF/ID/EX while an M-op runs
//   md_done            one-cycle pulse, md_result valid
//   md_result          M-op result (held until the next completion)

module alu_md_controller #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            RTypeID,
    input  logic            flush_i,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [3:0]      Operation,
    output logic            md_sel,
    output logic            stall_o,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // hi: product high half / partial remainder
    // lo: multiplier / dividend shifting into quotient
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] md_result_q, md_result_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;

    logic            is_m;
    logic            issue;

    // ------------------------------------------------------------
    // Base decode
    // ------------------------------------------------------------
    assign is_m = (ENABLE_M != 0) && (ALUOp == 2'b10) && RTypeID
                  && (Funct7 == 7'b0000001);

    always_comb begin
        Operation = 4'b0010;
        unique case (ALUOp)
            2'b00: Operation = 4'b0010;
            2'b01: begin
                unique case (Funct3)
                    3'b000:  Operation = 4'b1000;
                    3'b001:  Operation = 4'b1001;
                    3'b100:  Operation = 4'b1010;
                    3'b101:  Operation = 4'b1011;
                    default: Operation = 4'b0010;
                endcase
            end
            2'b10: begin
                unique case (Funct3)
                    3'b000: begin
                        if (Funct7 == 7'b0100000 && RTypeID)
                            Operation = 4'b0110;
                        else
                            Operation = 4'b0010;
                    end
                    3'b001: Operation = 4'b1101;
                    3'b010: Operation = 4'b0100;
                    3'b100: Operation = 4'b0101;
                    3'b101: begin
                        if (Funct7 == 7'b0100000)
                            Operation = 4'b1111;
                        else
                            Operation = 4'b1110;
                    end
                    3'b110:  Operation = 4'b0001;
                    3'b111:  Operation = 4'b0000;
                    default: Operation = 4'b0010;
                endcase
            end
            2'b11: Operation = 4'b0111;
            default: Operation = 4'b0010;
        endcase
        if (is_m)
            Operation = 4'b0000;
    end

    assign md_sel = is_m;

    // ------------------------------------------------------------
    // Issue-cycle operand preparation
    // ------------------------------------------------------------
    logic            is_div;
    logic            sa_i, sb_i;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div = Funct3[2];
        sa_i   = 1'b0;
        sb_i   = 1'b0;
        unique case (Funct3)
            F3_MULH: begin
                sa_i = src_a[XLEN-1];
                sb_i = src_b[XLEN-1];
            end
            F3_MULHSU: sa_i = src_a[XLEN-1];
            F3_DIV, F3_REM: begin
                sa_i = src_a[XLEN-1];
                sb_i = src_b[XLEN-1];
            end
            default: begin
                sa_i = 1'b0;
                sb_i = 1'b0;
            end
        endcase
        mag_a = sa_i ? -src_a : src_a;
        mag_b = sb_i ? -src_b : src_b;

        div_zero = is_div && (src_b == '0);
        div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM))
                   && (src_a == MIN_INT) && (src_b == '1);
        fast     = div_zero || div_ovf;

        // Funct3[1] splits quotient (DIV/DIVU) from remainder (REM/REMU)
        fast_res = '0;
        if (div_zero)
            fast_res = Funct3[1] ? src_a : '1;
        else if (div_ovf)
            fast_res = Funct3[1] ? '0 : MIN_INT;
    end

    assign issue = (state_q == IDLE) && valid_i && is_m && !flush_i;

    // ------------------------------------------------------------
    // Radix-2 datapath step
    // ------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   div_hi, div_lo;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        // Shift-add: add multiplicand into the high half on a set
        // multiplier bit, then shift the whole pair right.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

        // Restoring divide: bring in the next dividend bit, subtract
        // the divisor when it fits, shift the quotient bit in.
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh[XLEN-1:0] - opb_q;
        div_hi   = div_ge ? div_diff : div_sh[XLEN-1:0];
        div_lo   = {lo_q[XLEN-2:0], div_ge};

        step_hi = f3_q[2] ? div_hi : mul_hi;
        step_lo = f3_q[2] ? div_lo : mul_lo;

        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -step_lo : step_lo;
        rem_s  = rneg_q ? -step_hi : step_hi;

        if (f3_q[2])
            final_res = f3_q[1] ? rem_s : quo_s;
        else if (f3_q == F3_MUL)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        f3_d        = f3_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        md_result_d = md_result_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    f3_d   = Funct3;
                    neg_d  = sa_i ^ sb_i;
                    rneg_d = sa_i;
                    hi_d   = '0;
                    if (is_div) begin
                        lo_d  = mag_a;
                        opb_d = mag_b;
                    end else begin
                        lo_d  = mag_b;
                        opb_d = mag_a;
                    end
                    if (fast) begin
                        md_result_d = fast_res;
                        state_d     = DONE;
                    end else begin
                        cnt_d   = CW'(XLEN - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    md_result_d = final_res;
                    state_d     = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush abandons whatever is in flight without touching
        // the visible result.
        if (flush_i) begin
            state_d     = IDLE;
            md_result_d = md_result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            f3_q        <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            f3_q        <= f3_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            md_result_q <= md_result_d;
        end
    end

    assign stall_o   = (issue || (state_q == BUSY)) && !flush_i;
    assign md_done   = (state_q == DONE) && !flush_i;
    assign md_result = md_result_q;

endmodule

// File: tb/tb_alu_md_controller.sv
// Self-checking bench for alu_md_controller: directed decode and M-op
// corners plus randomized M-ops scored against an arithmetic model.

module tb_alu_md_controller;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_i;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            RTypeID;
    logic            flush_i;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [3:0]      Operation;
    logic            md_sel;
    logic            stall_o;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    alu_md_controller #(.XLEN(XLEN), .ENABLE_M(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .RTypeID   (RTypeID),
        .flush_i   (flush_i),
        .src_a     (src_a),
        .src_b     (src_b),
        .Operation (Operation),
        .md_sel    (md_sel),
        .stall_o   (stall_o),
        .md_done   (md_done),
        .md_result (md_result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_exp;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Reference M-op result from plain arithmetic.
    function automatic logic [XLEN-1:0] ref_md(logic [2:0] f3,
                                              logic [XLEN-1:0] a,
                                              logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea, eb, p;
        logic signed [XLEN-1:0] sa, sb;
        logic [XLEN-1:0] r;
        sa = a;
        sb = b;
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{XLEN{a[XLEN-1]}}, a}
                                       : {{XLEN{1'b0}}, a};
        eb = (f3 == 3'd1) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ea * eb;
        case (f3)
            3'd0: r = p[XLEN-1:0];
            3'd1, 3'd2, 3'd3: r = p[2*XLEN-1:XLEN];
            3'd4: begin
                if (b == '0) r = '1;
                else if (a == MIN_INT && b == '1) r = MIN_INT;
                else r = sa / sb;
            end
            3'd5: r = (b == '0) ? '1 : a / b;
            3'd6: begin
                if (b == '0) r = a;
                else if (a == MIN_INT && b == '1) r = '0;
                else r = sa % sb;
            end
            default: r = (b == '0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(logic [2:0] f3, logic [XLEN-1:0] a,
                                   logic [XLEN-1:0] b);
        if (!f3[2]) return 1'b0;
        if (b == '0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == MIN_INT && b == '1;
    endfunction

    function automatic logic [3:0] ref_op(logic [1:0] op, logic [6:0] f7,
                                          logic [2:0] f3, logic r);
        if (op == 2'b10 && r && f7 == 7'd1) return 4'b0000;
        case (op)
            2'b00: return 4'b0010;
            2'b11: return 4'b0111;
            2'b01: begin
                case (f3)
                    3'd0: return 4'b1000;
                    3'd1: return 4'b1001;
                    3'd4: return 4'b1010;
                    default: return 4'b1011;
                endcase
            end
            default: begin
                case (f3)
                    3'd0: return (f7 == 7'h20 && r) ? 4'b0110 : 4'b0010;
                    3'd1: return 4'b1101;
                    3'd2: return 4'b0100;
                    3'd4: return 4'b0101;
                    3'd5: return (f7 == 7'h20) ? 4'b1111 : 4'b1110;
                    3'd6: return 4'b0001;
                    default: return 4'b0000;
                endcase
            end
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && md_done) begin
            if (exp_q.size() == 0) begin
                check("spurious_md_done", 64'(md_done), 64'(0));
            end else begin
                check("md_result", 64'(md_result), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_idle();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ALUOp   = 2'b00;
        Funct7  = 7'd0;
        Funct3  = 3'd0;
        RTypeID = 1'b0;
    endtask

    task automatic dec(logic [1:0] op, logic [6:0] f7, logic [2:0] f3,
                       logic r);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ALUOp   = op;
        Funct7  = f7;
        Funct3  = f3;
        RTypeID = r;
        @(negedge clk);
        check("Operation", 64'(Operation), 64'(ref_op(op, f7, f3, r)));
        check("md_sel", 64'(md_sel),
              64'(op == 2'b10 && r && f7 == 7'd1));
    endtask

    task automatic issue_m(logic [2:0] f3, logic [XLEN-1:0] a,
                           logic [XLEN-1:0] b);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        flush_i = 1'b0;
        ALUOp   = 2'b10;
        RTypeID = 1'b1;
        Funct7  = 7'd1;
        Funct3  = f3;
        src_a   = a;
        src_b   = b;
    endtask

    task automatic run_md(logic [2:0] f3, logic [XLEN-1:0] a,
                          logic [XLEN-1:0] b);
        int stalls;
        bit seen;
        int exp_st;
        stalls = 0;
        seen   = 1'b0;
        exp_st = is_fast(f3, a, b) ? 1 : XLEN + 1;
        issue_m(f3, a, b);
        last_exp = ref_md(f3, a, b);
        exp_q.push_back(last_exp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            // operands are latched; scrambling them must not matter
            if (i >= 1) begin
                src_a = $urandom;
                src_b = $urandom;
            end
        end
        check("md_done_seen", 64'(seen), 64'(1));
        check("stall_cycles", 64'(stalls), 64'(exp_st));
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MIN_INT;
            3: return XLEN'(1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: bench timed out at %0t", $time);
        $fatal(1);
    end

    initial begin
        int dones;
        int stl;
        logic [1:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic r;
        logic [2:0] f3_list[4];
        f3_list = '{3'd0, 3'd1, 3'd4, 3'd5};

        reset   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ALUOp   = 2'b00;
        Funct7  = 7'd0;
        Funct3  = 3'd0;
        RTypeID = 1'b0;
        src_a   = '0;
        src_b   = '0;
        last_exp = '0;

        @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'(0));
        check("rst_done", 64'(md_done), 64'(0));
        check("rst_result", 64'(md_result), 64'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Directed decode
        dec(2'b10, 7'h20, 3'd0, 1'b1);
        dec(2'b10, 7'h20, 3'd0, 1'b0);
        dec(2'b10, 7'h20, 3'd5, 1'b1);
        dec(2'b01, 7'h00, 3'd5, 1'b0);
        dec(2'b10, 7'h01, 3'd3, 1'b1);

        // Random decode over the defined encodings
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            r  = 1'($urandom);
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'h01;
            endcase
            if (op == 2'b01) begin
                f3 = f3_list[$urandom_range(0, 3)];
            end else begin
                f3 = 3'($urandom_range(0, 7));
                if (op == 2'b10 && f3 == 3'd3) f3 = 3'd2;
            end
            if (f7 == 7'h01) r = 1'b1;
            dec(op, f7, f3, r);
        end

        // Directed M-op corners
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'd5, 32'd5, 32'd0);
        run_md(3'd7, 32'd5, 32'd0);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_md(3'd1, 32'hFFFF_FFF9, 32'd3);
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_idle();

        // Flush on BUSY cycle 10
        issue_m(3'd0, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_o), 64'(0));
        check("flush_done", 64'(md_done), 64'(0));
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        dones = 0;
        stl   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done) dones++;
            if (stall_o) stl++;
        end
        check("flush_no_done", 64'(dones), 64'(0));
        check("flush_idle", 64'(stl), 64'(0));
        check("flush_hold", 64'(md_result), 64'(last_exp));
        run_md(3'd0, 32'd3, 32'd4);
        set_idle();

        // Asynchronous reset mid-BUSY
        issue_m(3'd4, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        reset   = 1'b1;
        valid_i = 1'b0;
        #1;
        check("arst_stall", 64'(stall_o), 64'(0));
        check("arst_done", 64'(md_done), 64'(0));
        check("arst_result", 64'(md_result), 64'(0));
        #2;
        reset    = 1'b0;
        last_exp = '0;

        // Back-to-back divides
        run_md(3'd4, 32'd100, 32'd7);
        run_md(3'd4, 32'd100, 32'hFFFF_FFF9);

        // Randomized M-ops, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            run_md(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 1) == 0) set_idle();
        end
        set_idle();
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
